jtopl_timer_host: RTL and testbench

//  Host-bus register front end for the OPL timer pair: the CPU-facing side of the

---
 rtl/jtopl_timer_host.sv | 173 +++++++++++++++++
 tb/tb_jtopl_timer_host.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_timer_host.sv
// OPL timer host-bus front end: port decode, timer control
// registers, status readback and write-wait busy sequencing.
module jtopl_timer_host #(
  parameter int unsigned AW_WAIT = 12,
  parameter int unsigned DW_WAIT = 84,
  parameter int unsigned CW      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       irq_n,
  output logic       reg_we,
  output logic [7:0] reg_sel,
  output logic [7:0] reg_din
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_BUSY,
    DATA_BUSY
  } state_t;

  localparam logic [CW-1:0] AW_CNT = CW'(AW_WAIT);
  localparam logic [CW-1:0] DW_CNT = CW'(DW_WAIT);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wr_l_q, wr_l_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  value_a_q, value_a_d;
  logic [7:0]  value_b_q, value_b_d;
  logic        load_a_q, load_a_d;
  logic        load_b_q, load_b_d;
  logic        flagen_a_q, flagen_a_d;
  logic        flagen_b_q, flagen_b_d;
  logic        clr_q, clr_d;
  logic        reg_we_q, reg_we_d;
  logic [7:0]  reg_sel_q, reg_sel_d;
  logic [7:0]  reg_din_q, reg_din_d;

  logic wr;
  logic accept;

  assign wr     = ~cs_n & ~wr_n;
  assign busy   = (state_q != IDLE);
  // Edge-only accept: a strobe that began while busy never counts.
  assign accept = wr & ~wr_l_q & ~busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_l_d     = wr;
    dout_d     = {~irq_n, flag_A, flag_B, 5'b0};
    value_a_d  = value_a_q;
    value_b_d  = value_b_q;
    load_a_d   = load_a_q;
    load_b_d   = load_b_q;
    flagen_a_d = flagen_a_q;
    flagen_b_d = flagen_b_q;
    clr_d      = 1'b0;
    reg_we_d   = 1'b0;
    reg_sel_d  = reg_sel_q;
    reg_din_d  = reg_din_q;

    unique case (state_q)
      IDLE: begin
        if (accept && !addr) begin
          reg_sel_d = din;
          cnt_d     = AW_CNT;
          state_d   = (AW_WAIT == 0) ? IDLE : ADDR_BUSY;
        end else if (accept) begin
          reg_din_d = din;
          cnt_d     = DW_CNT;
          state_d   = (DW_WAIT == 0) ? IDLE : DATA_BUSY;
          unique case (reg_sel_q)
            8'h02: value_a_d = din;
            8'h03: value_b_d = din;
            8'h04: begin
              if (din[7]) begin
                clr_d = 1'b1;
              end else begin
                flagen_a_d = ~din[6];
                flagen_b_d = ~din[5];
                load_b_d   = din[1];
                load_a_d   = din[0];
              end
            end
            default: reg_we_d = 1'b1;
          endcase
        end
      end
      ADDR_BUSY, DATA_BUSY: begin
        if (cen) begin
          if (cnt_q <= ONE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_l_q     <= 1'b0;
      dout_q     <= '0;
      value_a_q  <= '0;
      value_b_q  <= '0;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      flagen_a_q <= 1'b1;
      flagen_b_q <= 1'b1;
      clr_q      <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_sel_q  <= '0;
      reg_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_l_q     <= wr_l_d;
      dout_q     <= dout_d;
      value_a_q  <= value_a_d;
      value_b_q  <= value_b_d;
      load_a_q   <= load_a_d;
      load_b_q   <= load_b_d;
      flagen_a_q <= flagen_a_d;
      flagen_b_q <= flagen_b_d;
      clr_q      <= clr_d;
      reg_we_q   <= reg_we_d;
      reg_sel_q  <= reg_sel_d;
      reg_din_q  <= reg_din_d;
    end
  end

  assign dout       = dout_q;
  assign value_A    = value_a_q;
  assign value_B    = value_b_q;
  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign flagen_A   = flagen_a_q;
  assign flagen_B   = flagen_b_q;
  assign clr_flag_A = clr_q;
  assign clr_flag_B = clr_q;
  assign reg_we     = reg_we_q;
  assign reg_sel    = reg_sel_q;
  assign reg_din    = reg_din_q;

endmodule

// File: tb/tb_jtopl_timer_host.sv
// Scoreboard bench for jtopl_timer_host: directed scenarios
// plus random bus traffic against a tick-count reference model.
module tb_jtopl_timer_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       addr = 1'b0;
  logic [7:0] din = '0;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       irq_n = 1'b1;
  logic [7:0] dout;
  logic       busy;
  logic [7:0] value_A, value_B;
  logic       load_A, load_B;
  logic       flagen_A, flagen_B;
  logic       clr_flag_A, clr_flag_B;
  logic       reg_we;
  logic [7:0] reg_sel, reg_din;

  jtopl_timer_host dut (
    .clk(clk), .rst(rst), .cen(cen),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr),
    .din(din), .dout(dout), .busy(busy),
    .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B),
    .clr_flag_A(clr_flag_A),
    .clr_flag_B(clr_flag_B),
    .flag_A(flag_A), .flag_B(flag_B),
    .irq_n(irq_n), .reg_we(reg_we),
    .reg_sel(reg_sel), .reg_din(reg_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [48:0] exp;
    string       tag;
  } sb_t;

  sb_t   sbq[$];
  int    total = 0;
  int    bad = 0;
  string phase = "reset";

  // Reference model: busy is just "ticks still owed".
  int         m_rem = 0;
  bit         m_prev = 0;
  logic [7:0] m_dout = 0, m_va = 0, m_vb = 0;
  logic       m_la = 0, m_lb = 0;
  logic       m_fa = 1, m_fb = 1;
  logic       m_ca = 0, m_cb = 0, m_we = 0;
  logic [7:0] m_sel = 0, m_rdin = 0;

  function automatic logic [48:0] act_vec();
    return {dout, busy, value_A, value_B,
            load_A, load_B, flagen_A, flagen_B,
            clr_flag_A, clr_flag_B, reg_we,
            reg_sel, reg_din};
  endfunction

  function automatic logic [48:0] exp_vec();
    return {m_dout, (m_rem != 0), m_va, m_vb,
            m_la, m_lb, m_fa, m_fb,
            m_ca, m_cb, m_we, m_sel, m_rdin};
  endfunction

  task automatic model(input logic r, input logic c,
                       input logic csn, input logic wrn,
                       input logic a, input logic [7:0] d);
    bit w, acc;
    sb_t it;
    if (r) begin
      m_rem = 0; m_prev = 0; m_dout = 0;
      m_va = 0; m_vb = 0; m_la = 0; m_lb = 0;
      m_fa = 1; m_fb = 1; m_ca = 0; m_cb = 0;
      m_we = 0; m_sel = 0; m_rdin = 0;
    end else begin
      w = !csn && !wrn;
      acc = w && !m_prev && (m_rem == 0);
      m_ca = 0; m_cb = 0; m_we = 0;
      if (m_rem > 0 && c) m_rem--;
      if (acc && !a) begin
        m_sel = d;
        m_rem = 12;
      end else if (acc) begin
        m_rdin = d;
        m_rem = 84;
        if (m_sel == 8'h02) m_va = d;
        else if (m_sel == 8'h03) m_vb = d;
        else if (m_sel == 8'h04 && d[7]) begin
          m_ca = 1; m_cb = 1;
        end else if (m_sel == 8'h04) begin
          m_fa = !d[6]; m_fb = !d[5];
          m_lb = d[1]; m_la = d[0];
        end else m_we = 1;
      end
      m_prev = w;
      m_dout = {!irq_n, flag_A, flag_B, 5'b0};
    end
    it.exp = exp_vec();
    it.tag = phase;
    sbq.push_back(it);
  endtask

  task automatic step(input logic r, input logic c,
                      input logic csn, input logic wrn,
                      input logic a, input logic [7:0] d);
    rst = r; cen = c; cs_n = csn;
    wr_n = wrn; addr = a; din = d;
    model(r, c, csn, wrn, a, d);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 400 && m_rem != 0; i++)
      step(0, 1, 1, 1, 0, 8'h00);
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    step(0, 1, 0, 0, a, d);
    step(0, 1, 0, 1, a, d);
    idle_wait();
  endtask

  // Monitor: one full output snapshot per clock edge.
  initial begin
    sb_t it;
    logic [48:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        act = act_vec();
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s t=%0t act=%h exp=%h",
                   it.tag, $time, act, it.exp);
        end
      end
    end
  end

  initial begin
    int k;
    logic [7:0] d;
    #2;
    step(1, 1, 1, 1, 0, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00);
    phase = "value_a";
    step(0, 1, 1, 1, 0, 8'h00);
    bus_wr(0, 8'h02);
    bus_wr(1, 8'hA5);

    phase = "load_clr";
    bus_wr(0, 8'h04);
    bus_wr(1, 8'h03);
    bus_wr(1, 8'h80);
    phase = "mask";
    bus_wr(1, 8'h60);

    phase = "drop_busy";
    bus_wr(0, 8'h02);
    step(0, 1, 0, 0, 0, 8'h02);
    step(0, 1, 0, 1, 0, 8'h02);
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, 1, 0, 8'h00);
    step(0, 1, 0, 0, 1, 8'h5A);
    step(0, 1, 0, 1, 1, 8'h5A);
    idle_wait();

    phase = "long_strobe";
    bus_wr(0, 8'h20);
    for (int i = 0; i < 200; i++)
      step(0, 1, 0, 0, 1, 8'h77);
    step(0, 1, 0, 1, 1, 8'h77);
    idle_wait();

    phase = "cen_gap";
    bus_wr(0, 8'h03);
    step(0, 1, 0, 0, 1, 8'h3C);
    for (int i = 0; i < 200 && m_rem != 0; i++)
      step(0, i[0], 1, 1, 0, 8'h00);

    phase = "status";
    flag_A = 1; irq_n = 0;
    step(0, 1, 1, 1, 0, 8'h00);
    step(0, 1, 1, 1, 0, 8'h00);
    flag_B = 1;
    step(0, 1, 1, 1, 0, 8'h00);

    phase = "rst_mid";
    bus_wr(0, 8'h04);
    step(0, 1, 0, 0, 1, 8'h61);
    step(0, 1, 0, 1, 1, 8'h61);
    for (int i = 0; i < 5; i++)
      step(0, 1, 1, 1, 0, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00);
    step(0, 1, 1, 1, 0, 8'h00);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      flag_A = 1'($urandom);
      flag_B = 1'($urandom);
      irq_n = 1'($urandom);
      k = int'($urandom_range(0, 7));
      d = 8'($urandom);
      if (k < 3) d = 8'(k + 2);
      if (k == 3) d = {1'b1, d[6:0]};
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0),
           1'($urandom), d);
    end

    phase = "drain";
    step(0, 1, 1, 1, 0, 8'h00);
    @(posedge clk);
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d req=0",
               sbq.size());
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
